neur_result_packer: RTL
=======================

// Module: neur_result_packer
// PURPOSE
//  Write-back side of the mixed-precision MAC path: the inverse of the operand unpacker.
//  Takes one signed accumulator result per handshake, requantizes it (round, shift, saturate)
//  to 16/8/4/2 bits and packs lanes MSB-first into 32-bit words for the LSU/register write.
//  A word goes out when full, or on flush with a partial-lane count.
// PARAMETERS
//  ACC_W   32  width of incoming accumulator value (signed, two's complement)
//  SHIFT_W 5   width of requantization right-shift amount
// PORTS
//  clk_i         in   1        clock; one clock domain
//  rst_i         in   1        reset, asynchronous, active-high
//  in_valid_i    in   1        accumulator value valid
//  in_ready_o    out  1        packer can accept value/flush this cycle
//  in_acc_i      in   ACC_W    signed accumulator value
//  mode_i        in   2        00: 8b x4, 01: 4b x8, 10: 2b x16, 11: 16b x2
//  shift_i       in   SHIFT_W  arithmetic right-shift amount, 0..31
//  unsigned_i    in   1        1: saturate to [0, 2^N-1], 0: to [-2^(N-1), 2^(N-1)-1]
//  flush_i       in   1        emit partial word; honoured only when in_ready_o=1
//  out_valid_o   out  1        packed word valid
//  out_ready_i   in   1        consumer accepts word
//  out_word_o    out  32       packed word
//  out_count_o   out  5        number of valid lanes in out_word_o (1..16)
// BEHAVIOUR
//  - Reset: state IDLE, lane count 0, out_valid_o=0, out_word_o=0, out_count_o=0, latched mode=00.
//    Reset mid-word drops the partial word; no output is produced for it.
//  - Lane width N and lanes L come from mode: 00 N=8,L=4 | 01 N=4,L=8 | 10 N=2,L=16 | 11 N=16,L=2.
//  - mode_i, unsigned_i and shift_i are latched on the first lane of each word (count==0).
//    Changes mid-word are ignored until that word is emitted.
//  - Requant, all combinational on the accepted cycle, computed in ACC_W+1 bits:
//    r = (acc + (s>0 ? 2^(s-1) : 0)) >>> s, i.e. round half up. Then saturate r to the N-bit range.
//  - Packing: lane k (0 = first accepted) occupies out bits [31-k*N -: N]. Unfilled lanes are 0.
//  - Input accept: in_valid_i & in_ready_o. Flush accept: flush_i & in_ready_o.
//  - in_ready_o = ~out_valid_o | out_ready_i. A word may drain and a new value be accepted in one cycle.
//  - FSM states:
//    IDLE (count=0) --accept--> FILL.
//    FILL --accept, count+1==L--> HOLD. FILL --flush--> HOLD.
//    HOLD --out_ready_i--> IDLE, or FILL if a value is accepted in the same cycle.
//  - Latency: out_valid_o rises the cycle after the completing value or the flush is accepted.
//    out_word_o and out_count_o stay stable while out_valid_o=1 and out_ready_i=0.
//  - Value and flush in the same cycle: the value is packed first, then the word is emitted.
//    count = filled lanes, or L if that value completed the word.
//  - Flush in IDLE with no value: no-op, no output word.
//  - After handshake: out_valid_o=0 unless a new word completes; out_word_o holds its last value.
//  - Count never wraps: the word is emitted exactly at count==L.
// TESTING
//  1. mode 00, signed, s=0, values 1,2,3,4 -> one word 0x01020304, count 4.
//  2. mode 00, signed, s=0, values 300,-200,127,-128 -> 0x7F807F80.
//     Same values with unsigned_i=1 -> 0xFF007F00.
//  3. mode 01, signed, s=1, eight values of 7 -> (7+1)>>1=4 in each lane -> 0x44444444, count 8.
//  4. mode 00, values 0x11,0x22,0x33, then flush -> 0x11223300, count 3.
//     A second flush while empty produces no word.
//  5. mode 11, out_ready_i held low 5 cycles after word 0x7FFF8000 (values 40000,-40000):
//     word stays stable and in_ready_o=0 throughout. Raising out_ready_i with a new value in the
//     same cycle drains the word and accepts the value.
//  6. mode 00, accept 2 values, assert rst_i mid-word, then 5,6,7,8 -> single word 0x05060708;
//     no partial word from before reset appears.

Source files
------------

// File: rtl/neur_result_packer.sv
// Requantizes signed accumulator results (round half up, shift, saturate) to 16/8/4/2-bit lanes
// and packs them MSB-first into 32-bit words, emitted when full or on flush.
module neur_result_packer #(
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [ACC_W-1:0]   in_acc_i,
  input  logic [1:0]         mode_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               unsigned_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        out_word_o,
  output logic [4:0]         out_count_o,
  output logic [1:0]         dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
  // Producers hold payload stable while valid is high and ready is low; ready never waits on valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic signed [ACC_W:0] ONE    = {{ACC_W{1'b0}}, 1'b1};
  localparam logic [SHIFT_W-1:0]    SH_ONE = SHIFT_W'(1);

  state_e             state_q, state_d;
  logic [4:0]         count_q, count_d;
  logic [31:0]        buf_q, buf_d;
  logic [1:0]         mode_q;
  logic               uns_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [31:0]        word_d;
  logic [4:0]         cnt_d;

  logic               first, accept, flush_acc, emit;
  logic [1:0]         eff_mode;
  logic               eff_uns;
  logic [SHIFT_W-1:0] eff_shift;
  logic [4:0]         n_eff, lanes, fill_cnt;
  logic [31:0]        fill_buf, lane_word;
  logic [15:0]        lmask, lane_bits;
  logic [5:0]         pos;

  logic signed [ACC_W:0] ext, rnd, rsum, rq, half, smax, smin, sat;

  assign out_valid_o = (state_q == HOLD);
  assign in_ready_o  = ~out_valid_o | out_ready_i;
  assign dbg_state_o = state_q;

  assign accept    = in_valid_i & in_ready_o;
  assign flush_acc = flush_i & in_ready_o;

  // Word parameters come from the inputs on the first lane and from the latched copy afterwards.
  assign first     = (count_q == 5'd0);
  assign eff_mode  = first ? mode_i     : mode_q;
  assign eff_uns   = first ? unsigned_i : uns_q;
  assign eff_shift = first ? shift_i    : shift_q;

  always_comb begin
    n_eff = 5'd8;
    lanes = 5'd4;
    case (eff_mode)
      2'b00: begin n_eff = 5'd8;  lanes = 5'd4;  end
      2'b01: begin n_eff = 5'd4;  lanes = 5'd8;  end
      2'b10: begin n_eff = 5'd2;  lanes = 5'd16; end
      default: begin n_eff = 5'd16; lanes = 5'd2; end
    endcase
  end

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    ext = {in_acc_i[ACC_W-1], in_acc_i};
    rnd = '0;
    if (eff_shift != '0) rnd = ONE <<< (eff_shift - SH_ONE);
    rsum = ext + rnd;
    rq   = rsum >>> eff_shift;
    half = ONE <<< (n_eff - 5'd1);
    if (eff_uns) begin
      smin = '0;
      smax = (half <<< 1) - ONE;
    end else begin
      smin = -half;
      smax = half - ONE;
    end
    if (rq > smax)      sat = smax;
    else if (rq < smin) sat = smin;
    else                sat = rq;
    lmask     = 16'((17'd1 << n_eff) - 17'd1);
    lane_bits = sat[15:0] & lmask;
    pos       = 6'd32 - ((6'(count_q) + 6'd1) * 6'(n_eff));
    lane_word = {16'd0, lane_bits} << pos;
  end

  always_comb begin
    fill_cnt = accept ? count_q + 5'd1 : count_q;
    fill_buf = accept ? (buf_q | lane_word) : buf_q;
    emit     = (accept && (fill_cnt == lanes)) || (flush_acc && (fill_cnt != 5'd0));
    count_d  = emit ? 5'd0  : fill_cnt;
    buf_d    = emit ? 32'd0 : fill_buf;
    word_d   = emit ? fill_buf : out_word_o;
    cnt_d    = emit ? fill_cnt : out_count_o;

    state_d = state_q;
    if (emit)                               state_d = HOLD;
    else if (state_q == HOLD && !out_ready_i) state_d = HOLD;
    else if (fill_cnt != 5'd0)              state_d = FILL;
    else                                    state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= 5'd0;
      buf_q       <= 32'd0;
      out_word_o  <= 32'd0;
      out_count_o <= 5'd0;
      mode_q      <= 2'b00;
      uns_q       <= 1'b0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      buf_q       <= buf_d;
      out_word_o  <= word_d;
      out_count_o <= cnt_d;
      if (accept && first) begin
        mode_q  <= mode_i;
        uns_q   <= unsigned_i;
        shift_q <= shift_i;
      end
    end
  end

endmodule
